// File: rtl/board_pkg.sv
// Shared types and sizes for the magic-square board loader.
package board_pkg;
    localparam int NUM_CELLS = 9;
    localparam int NUM_LINES = 8;

    typedef logic [3:0] digit_t;
    typedef logic [4:0] sum_t;

    typedef enum logic [1:0] {LOAD, SUM, DONE} loader_state_t;
endpackage

// File: rtl/line_cell_lut.sv
// Maps a line index (rows, cols, diag, anti-diag) to its three row-major cell indices.
module line_cell_lut (
    input  logic [2:0] line_idx,
    output logic [3:0] cell_a,
    output logic [3:0] cell_b,
    output logic [3:0] cell_c
);
    always_comb begin
        cell_a = 4'd0;
        cell_b = 4'd0;
        cell_c = 4'd0;
        case (line_idx)
            3'd0: begin cell_a = 4'd0; cell_b = 4'd1; cell_c = 4'd2; end
            3'd1: begin cell_a = 4'd3; cell_b = 4'd4; cell_c = 4'd5; end
            3'd2: begin cell_a = 4'd6; cell_b = 4'd7; cell_c = 4'd8; end
            3'd3: begin cell_a = 4'd0; cell_b = 4'd3; cell_c = 4'd6; end
            3'd4: begin cell_a = 4'd1; cell_b = 4'd4; cell_c = 4'd7; end
            3'd5: begin cell_a = 4'd2; cell_b = 4'd5; cell_c = 4'd8; end
            3'd6: begin cell_a = 4'd0; cell_b = 4'd4; cell_c = 4'd8; end
            3'd7: begin cell_a = 4'd2; cell_b = 4'd4; cell_c = 4'd6; end
        endcase
    end
endmodule

// File: rtl/board_loader.sv
// Loads nine digits serially, then computes the eight line sums one per cycle.
// Optional undo of the last digit is enabled with `define BOARD_UNDO_EN.
module board_loader
    import board_pkg::*;
(
    input  logic       clock,
    input  logic       reset_L,
    input  logic       clear,
    input  logic [3:0] digit_in,
    input  logic       digit_valid,
    output logic       digit_ready,
    input  logic       undo,
    output logic [3:0] cell_count,
    output logic [3:0] num1,
    output logic [3:0] num2,
    output logic [3:0] num3,
    output logic [3:0] num4,
    output logic [3:0] num5,
    output logic [3:0] num6,
    output logic [3:0] num7,
    output logic [3:0] num8,
    output logic [3:0] num9,
    output logic [4:0] s1,
    output logic [4:0] s2,
    output logic [4:0] s3,
    output logic [4:0] s4,
    output logic [4:0] s5,
    output logic [4:0] s6,
    output logic [4:0] s7,
    output logic [4:0] s8,
    output logic       board_done
);
    loader_state_t state, state_nxt;
    logic [NUM_CELLS-1:0][3:0] cells;
    logic [NUM_LINES-1:0][4:0] sums;
    logic [3:0] count;
    logic [3:0] line_idx;
    logic [3:0] cell_a, cell_b, cell_c;
    sum_t line_sum;
    logic accept, do_undo, undo_gate;

`ifdef BOARD_UNDO_EN
    assign undo_gate = undo;
    assign do_undo   = (state == LOAD) && (count != 4'd0) && undo && !clear;
`else
    logic unused_undo;
    assign unused_undo = undo;
    assign undo_gate   = 1'b0;
    assign do_undo     = 1'b0;
`endif

    line_cell_lut u_lut (
        .line_idx (line_idx[2:0]),
        .cell_a   (cell_a),
        .cell_b   (cell_b),
        .cell_c   (cell_c)
    );

    assign line_sum = sum_t'(cells[cell_a]) + sum_t'(cells[cell_b]) + sum_t'(cells[cell_c]);

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) state <= LOAD;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        digit_ready = 1'b0;
        case (state)
            LOAD: begin
                digit_ready = (count < 4'd9) && !clear && !undo_gate;
                if (digit_valid && digit_ready && count == 4'd8) state_nxt = SUM;
            end
            // line_idx reaching 8 means the last sum landed on the previous edge
            SUM:     if (line_idx == 4'd8) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = LOAD;
        endcase
        if (clear) state_nxt = LOAD;
    end

    assign accept = digit_valid && digit_ready;

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            cells    <= '0;
            sums     <= '0;
            count    <= 4'd0;
            line_idx <= 4'd0;
        end else if (clear) begin
            cells    <= '0;
            sums     <= '0;
            count    <= 4'd0;
            line_idx <= 4'd0;
        end else if (accept) begin
            cells[count] <= digit_in;
            count        <= count + 4'd1;
            line_idx     <= 4'd0;
        end else if (do_undo) begin
            cells[count - 4'd1] <= 4'd0;
            count               <= count - 4'd1;
        end else if (state == SUM && line_idx < 4'd8) begin
            sums[line_idx[2:0]] <= line_sum;
            line_idx            <= line_idx + 4'd1;
        end
    end

    assign cell_count = count;
    assign board_done = (state == DONE);

    assign num1 = cells[0];
    assign num2 = cells[1];
    assign num3 = cells[2];
    assign num4 = cells[3];
    assign num5 = cells[4];
    assign num6 = cells[5];
    assign num7 = cells[6];
    assign num8 = cells[7];
    assign num9 = cells[8];

    assign s1 = sums[0];
    assign s2 = sums[1];
    assign s3 = sums[2];
    assign s4 = sums[3];
    assign s5 = sums[4];
    assign s6 = sums[5];
    assign s7 = sums[6];
    assign s8 = sums[7];
endmodule

// File: tb/tb_board_loader.sv
// Self-checking bench for board_loader against a digit-queue board model.
module tb_board_loader;
    logic       clock = 1'b0;
    logic       reset_L, clear, digit_valid, undo;
    logic [3:0] digit_in;
    logic       digit_ready, board_done;
    logic [3:0] cell_count;
    logic [3:0] num [9];
    logic [4:0] s [8];

    int n_cmp = 0;
    int n_bad = 0;

    int model_cells [9];
    int model_count;

    always #5 clock = ~clock;

    board_loader dut (
        .clock(clock), .reset_L(reset_L), .clear(clear),
        .digit_in(digit_in), .digit_valid(digit_valid), .digit_ready(digit_ready),
        .undo(undo), .cell_count(cell_count),
        .num1(num[0]), .num2(num[1]), .num3(num[2]), .num4(num[3]), .num5(num[4]),
        .num6(num[5]), .num7(num[6]), .num8(num[7]), .num9(num[8]),
        .s1(s[0]), .s2(s[1]), .s3(s[2]), .s4(s[3]),
        .s5(s[4]), .s6(s[5]), .s7(s[6]), .s8(s[7]),
        .board_done(board_done)
    );

    // ---- board model: a list of placed digits and the line-sum rules ----
    function automatic void model_clear();
        for (int i = 0; i < 9; i++) model_cells[i] = 0;
        model_count = 0;
    endfunction

    function automatic void model_push(int d);
        model_cells[model_count] = d;
        model_count++;
    endfunction

    function automatic int exp_sum(int l);
        int b0, b4;
        b0 = model_cells[0];
        b4 = model_cells[4];
        if (l < 3)       return model_cells[3*l] + model_cells[3*l+1] + model_cells[3*l+2];
        else if (l < 6)  return model_cells[l-3] + model_cells[l] + model_cells[l+3];
        else if (l == 6) return b0 + b4 + model_cells[8];
        else             return model_cells[2] + b4 + model_cells[6];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        clear = 1'b0; digit_valid = 1'b0; undo = 1'b0; digit_in = 4'd0;
    endtask

    // Presents one digit for one cycle; returns the ready seen before the edge.
    task automatic push_digit(input int d, output logic rdy);
        digit_valid = 1'b1;
        digit_in    = 4'(d);
        #1;
        rdy = digit_ready;
        tick();
        digit_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_L = 1'b0;
        tick();
        tick();
        reset_L = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (cell_count !== 4'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", cell_count); end
        n_cmp++;
        if (board_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", board_done); end
        for (int i = 0; i < 9; i++) begin
            n_cmp++;
            if (num[i] !== 4'd0) begin n_bad++; $display("FAIL reset_num%0d got %0d want 0", i+1, num[i]); end
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (s[i] !== 5'd0) begin n_bad++; $display("FAIL reset_s%0d got %0d want 0", i+1, s[i]); end
        end
        #1;
        n_cmp++;
        if (digit_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", digit_ready); end
    endtask

    // Loads a board with optional idle gaps, then checks done timing, cells and sums.
    task automatic load_and_check(input string tag, input int b [9], input int gap);
        logic rdy;
        for (int i = 0; i < 9; i++) begin
            for (int g = 0; g < gap; g++) begin
                tick();
                n_cmp++;
                if (cell_count !== 4'(model_count)) begin
                    n_bad++; $display("FAIL %s_gap_count got %0d want %0d", tag, cell_count, model_count);
                end
            end
            push_digit(b[i], rdy);
            n_cmp++;
            if (rdy !== 1'b1) begin n_bad++; $display("FAIL %s_ready[%0d] got %b want 1", tag, i, rdy); end
            model_push(b[i]);
            n_cmp++;
            if (cell_count !== 4'(model_count)) begin
                n_bad++; $display("FAIL %s_count[%0d] got %0d want %0d", tag, i, cell_count, model_count);
            end
        end
        digit_valid = 1'b1;
        digit_in    = 4'd1;
        #1;
        n_cmp++;
        if (digit_ready !== 1'b0) begin n_bad++; $display("FAIL %s_ready_after9 got %b want 0", tag, digit_ready); end
        for (int e = 1; e <= 9; e++) begin
            tick();
            if (e == 8) begin
                n_cmp++;
                if (board_done !== 1'b0) begin n_bad++; $display("FAIL %s_done_early got %b want 0", tag, board_done); end
            end
        end
        n_cmp++;
        if (board_done !== 1'b1) begin n_bad++; $display("FAIL %s_done_edge9 got %b want 1", tag, board_done); end
        tick();
        digit_valid = 1'b0;
        n_cmp++;
        if (cell_count !== 4'd9 || board_done !== 1'b1) begin
            n_bad++; $display("FAIL %s_done_hold got count=%0d done=%b want 9/1", tag, cell_count, board_done);
        end
        for (int i = 0; i < 9; i++) begin
            n_cmp++;
            if (num[i] !== 4'(model_cells[i])) begin
                n_bad++; $display("FAIL %s_num%0d got %0d want %0d", tag, i+1, num[i], model_cells[i]);
            end
        end
        for (int l = 0; l < 8; l++) begin
            n_cmp++;
            if (s[l] !== 5'(exp_sum(l))) begin
                n_bad++; $display("FAIL %s_s%0d got %0d want %0d", tag, l+1, s[l], exp_sum(l));
            end
        end
    endtask

    task automatic test_magic();
        int b [9] = '{2,7,6,9,5,1,4,3,8};
        do_reset();
        load_and_check("magic", b, 0);
        for (int l = 0; l < 8; l++) begin
            n_cmp++;
            if (s[l] !== 5'd15) begin n_bad++; $display("FAIL magic_fixed_s%0d got %0d want 15", l+1, s[l]); end
        end
    endtask

    task automatic test_sequential();
        int b [9] = '{1,2,3,4,5,6,7,8,9};
        int want [8] = '{6,15,24,12,15,18,15,15};
        do_reset();
        load_and_check("seq", b, 0);
        for (int l = 0; l < 8; l++) begin
            n_cmp++;
            if (s[l] !== 5'(want[l])) begin n_bad++; $display("FAIL seq_fixed_s%0d got %0d want %0d", l+1, s[l], want[l]); end
        end
    endtask

    task automatic test_gapped();
        int b [9] = '{1,2,3,4,5,6,7,8,9};
        do_reset();
        load_and_check("gap", b, 2);
    endtask

    task automatic test_clear_mid_load();
        logic rdy;
        int b [9];
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push_digit(i + 3, rdy);
            model_push(i + 3);
        end
        clear = 1'b1; digit_valid = 1'b1; digit_in = 4'd9;
        #1;
        n_cmp++;
        if (digit_ready !== 1'b0) begin n_bad++; $display("FAIL clr_ready got %b want 0", digit_ready); end
        tick();
        idle_inputs();
        model_clear();
        n_cmp++;
        if (cell_count !== 4'd0) begin n_bad++; $display("FAIL clr_count got %0d want 0", cell_count); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (num[i] !== 4'd0) begin n_bad++; $display("FAIL clr_num%0d got %0d want 0", i+1, num[i]); end
        end
        for (int i = 0; i < 9; i++) b[i] = int'($urandom_range(0, 9));
        load_and_check("clr_reload", b, 0);
    endtask

    task automatic test_clear_mid_sum();
        logic rdy;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            push_digit(9 - i, rdy);
            model_push(9 - i);
        end
        tick(); tick(); tick(); tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int l = 0; l < 8; l++) begin
            n_cmp++;
            if (s[l] !== 5'd0) begin n_bad++; $display("FAIL clrsum_s%0d got %0d want 0", l+1, s[l]); end
        end
        n_cmp++;
        if (cell_count !== 4'd0 || num[0] !== 4'd0) begin
            n_bad++; $display("FAIL clrsum_cells got count=%0d num1=%0d want 0/0", cell_count, num[0]);
        end
        tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick();
        n_cmp++;
        if (board_done !== 1'b0) begin n_bad++; $display("FAIL clrsum_done got %b want 0", board_done); end
    endtask

    task automatic test_reset_mid_sum();
        logic rdy;
        int b [9] = '{8,1,6,3,5,7,4,9,2};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            push_digit(b[i], rdy);
            model_push(b[i]);
        end
        tick(); tick(); tick();
        for (int l = 0; l < 3; l++) begin
            n_cmp++;
            if (s[l] !== 5'(exp_sum(l))) begin n_bad++; $display("FAIL rstsum_pre_s%0d got %0d want %0d", l+1, s[l], exp_sum(l)); end
        end
        n_cmp++;
        if (s[3] !== 5'd0) begin n_bad++; $display("FAIL rstsum_pre_s4 got %0d want 0", s[3]); end
        #2;
        reset_L = 1'b0;
        #1;
        n_cmp++;
        if (cell_count !== 4'd0 || board_done !== 1'b0) begin
            n_bad++; $display("FAIL rstsum_async got count=%0d done=%b want 0/0", cell_count, board_done);
        end
        for (int l = 0; l < 8; l++) begin
            n_cmp++;
            if (s[l] !== 5'd0) begin n_bad++; $display("FAIL rstsum_s%0d got %0d want 0", l+1, s[l]); end
        end
        n_cmp++;
        if (num[4] !== 4'd0) begin n_bad++; $display("FAIL rstsum_num5 got %0d want 0", num[4]); end
        tick(); tick();
        reset_L = 1'b1;
        model_clear();
        for (int e = 0; e < 10; e++) begin
            tick();
            n_cmp++;
            if (board_done !== 1'b0) begin n_bad++; $display("FAIL rstsum_done[%0d] got %b want 0", e, board_done); end
        end
    endtask

    task automatic test_undo();
        logic rdy;
        logic exp_rdy;
        int exp_count, exp_n3, exp_n4;
        do_reset();
        push_digit(4, rdy);
        push_digit(9, rdy);
        push_digit(2, rdy);
`ifdef BOARD_UNDO_EN
        exp_rdy = 1'b0; exp_count = 2; exp_n3 = 0; exp_n4 = 0;
`else
        exp_rdy = 1'b1; exp_count = 4; exp_n3 = 2; exp_n4 = 7;
`endif
        undo = 1'b1; digit_valid = 1'b1; digit_in = 4'd7;
        #1;
        n_cmp++;
        if (digit_ready !== exp_rdy) begin n_bad++; $display("FAIL undo_ready got %b want %b", digit_ready, exp_rdy); end
        tick();
        idle_inputs();
        n_cmp++;
        if (cell_count !== 4'(exp_count)) begin n_bad++; $display("FAIL undo_count got %0d want %0d", cell_count, exp_count); end
        n_cmp++;
        if (num[2] !== 4'(exp_n3)) begin n_bad++; $display("FAIL undo_num3 got %0d want %0d", num[2], exp_n3); end
        n_cmp++;
        if (num[3] !== 4'(exp_n4)) begin n_bad++; $display("FAIL undo_num4 got %0d want %0d", num[3], exp_n4); end
    endtask

    task automatic test_random();
        int b [9];
        for (int r = 0; r < 5; r++) begin
            clear = 1'b1;
            tick();
            clear = 1'b0;
            model_clear();
            n_cmp++;
            if (cell_count !== 4'd0 || board_done !== 1'b0) begin
                n_bad++; $display("FAIL rnd%0d_clear got count=%0d done=%b want 0/0", r, cell_count, board_done);
            end
            for (int i = 0; i < 9; i++) b[i] = int'($urandom_range(0, 9));
            load_and_check($sformatf("rnd%0d", r), b, int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        reset_L = 1'b0;
        idle_inputs();
        test_reset();
        test_magic();
        test_sequential();
        test_gapped();
        test_clear_mid_load();
        test_clear_mid_sum();
        test_reset_mid_sum();
        test_undo();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
